// File: rtl/tanh_pkg.sv
// tanh_pkg: shared types and Q2.30 series coefficients for the tanh engine.
// Coefficient magnitudes are truncated from the exact Taylor fractions.
package tanh_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SQR,
        ITER,
        DONE
    } state_t;

    localparam int MAX_TERMS = 8;
    localparam int COEF_W    = 32;
    localparam int COEF_FRAC = 30;

    // 1, 1/3, 2/15, 17/315, 62/2835, 1382/155925, 21844/6081075, 929569/638512875
    localparam logic [COEF_W-1:0] COEF_Q30 [MAX_TERMS] = '{
        32'h4000_0000,
        32'h1555_5555,
        32'h0888_8888,
        32'h0374_3743,
        32'h0166_4F48,
        32'h0091_371A,
        32'h003A_DA7A,
        32'h0017_DA36
    };

endpackage

// File: rtl/tanh_coef_rom.sv
// tanh_coef_rom: combinational term index to coefficient lookup,
// realigned from Q2.30 to the datapath fraction width.
module tanh_coef_rom
    import tanh_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12
) (
    input  logic [2:0]       idx,
    output logic [WIDTH-1:0] coef
);

    assign coef = WIDTH'(COEF_Q30[idx] >> (COEF_FRAC - FRAC));

endmodule

// File: rtl/tanh_series_unit.sv
// tanh_series_unit: Taylor-series tanh(x) on |x| with sign restore and saturation.
// Define TANH_CLAMP_EN to return +-1.0 early for |x| >= CLAMP_X.
module tanh_series_unit
    import tanh_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter int               FRAC    = 12,
    parameter int               TERMS   = 6,
    parameter logic [WIDTH-1:0] CLAMP_X = WIDTH'(2 << FRAC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Y
);

    localparam int ACC_W = WIDTH + 4;
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1) << FRAC;
    localparam logic [WIDTH-1:0] NEG_ONE = ~ONE + 1'b1;
    localparam logic signed [ACC_W-1:0] ONE_ACC = ACC_W'(1) << FRAC;
    localparam logic [2:0] LAST = 3'(TERMS - 1);

`ifdef TANH_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    state_t state, state_nxt;

    logic [WIDTH-1:0] a, term, sqr, abs_x, coef, r, y_nxt;
    logic [2*WIDTH-1:0] sqr_p, term_p, coef_p;
    logic signed [ACC_W-1:0] acc, acc_nxt, delta;
    logic [2:0] idx;
    logic neg, last, clamp_hit;

    function automatic logic [WIDTH-1:0] sat_q(input logic [2*WIDTH-1:0] p);
        logic [2*WIDTH-1:0] s;
        s = p >> FRAC;
        if (s > {{WIDTH{1'b0}}, MAX_POS}) return MAX_POS;
        return s[WIDTH-1:0];
    endfunction

    tanh_coef_rom #(
        .WIDTH(WIDTH),
        .FRAC (FRAC)
    ) u_rom (
        .idx (idx),
        .coef(coef)
    );

    always_comb begin
        abs_x = X;
        if (X == MIN_NEG) abs_x = MAX_POS;
        else if (X[WIDTH-1]) abs_x = -X;
    end

    assign sqr_p  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, a};
    assign term_p = {{WIDTH{1'b0}}, term} * {{WIDTH{1'b0}}, sqr};
    assign coef_p = {{WIDTH{1'b0}}, coef} * {{WIDTH{1'b0}}, term};
    assign delta  = ACC_W'(coef_p >> FRAC);
    assign acc_nxt = idx[0] ? acc - delta : acc + delta;
    assign last = (idx == LAST);

    // Clamp decision is taken in the SQR slot so Y lands one edge after capture.
    assign clamp_hit = CLAMP_EN && (a >= CLAMP_X);

    always_comb begin
        r = acc_nxt[WIDTH-1:0];
        if (acc_nxt < 0) r = '0;
        else if (acc_nxt > ONE_ACC) r = ONE;
        y_nxt = neg ? -r : r;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SQR;
            SQR:     state_nxt = clamp_hit ? DONE : ITER;
            ITER:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a    <= '0;
            neg  <= 1'b0;
            acc  <= '0;
            term <= '0;
            sqr  <= '0;
            idx  <= '0;
            Y    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a    <= abs_x;
                        neg  <= X[WIDTH-1];
                        acc  <= '0;
                        term <= abs_x;
                        idx  <= '0;
                    end
                end
                SQR: begin
                    sqr <= sat_q(sqr_p);
                    if (clamp_hit) Y <= neg ? NEG_ONE : ONE;
                end
                ITER: begin
                    acc  <= acc_nxt;
                    term <= sat_q(term_p);
                    idx  <= idx + 3'd1;
                    if (last) Y <= y_nxt;
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_tanh_series_unit.sv
// tb_tanh_series_unit: directed vector table plus reset, busy-start
// and single-term sequences for tanh_series_unit.
module tb_tanh_series_unit;

`ifdef TANH_CLAMP_EN
    localparam int CL_LAT = 1;
`else
    localparam int CL_LAT = 7;
`endif

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        int          tol;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    logic [15:0] x0 = '0, x1 = '0;
    logic ready0, done0, ready1, done1;
    logic [15:0] y0, y1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tanh_series_unit u_dut (
        .clk  (clk),
        .rst  (rst),
        .start(start0),
        .X    (x0),
        .ready(ready0),
        .done (done0),
        .Y    (y0)
    );

    tanh_series_unit #(.TERMS(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .start(start1),
        .X    (x1),
        .ready(ready1),
        .done (done1),
        .Y    (y1)
    );

    task automatic check(input string name, input int act, input int exp, input int tol);
        total++;
        if (act - exp > tol || exp - act > tol) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic run0(input logic [15:0] x, output int lat, output logic [15:0] y);
        @(negedge clk);
        x0 = x;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        check("busy_ready", int'(ready0), 0, 0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done0 && lat < 40);
        y = y0;
        @(posedge clk);
        #1;
        check("pulse_end", int'({done0, ready0}), 1, 0);
    endtask

    vec_t vecs [8];
    logic [15:0] ys [8];
    logic [15:0] yv, negp;
    int lat, dones;

    initial begin
        vecs[0] = '{16'h0800, 16'h0765, 3, 7};
        vecs[1] = '{16'hF800, 16'hF89B, 3, 7};
        vecs[2] = '{16'h0000, 16'h0000, 0, 7};
        vecs[3] = '{16'h0400, 16'h03EB, 0, 7};
        vecs[4] = '{16'h1000, 16'h0C25, 0, 7};
        vecs[5] = '{16'hF000, 16'hF3DB, 0, 7};
        vecs[6] = '{16'h3000, 16'h1000, 0, CL_LAT};
        vecs[7] = '{16'h8000, 16'hF000, 0, CL_LAT};

        #12;
        check("rst_ready", int'(ready0), 1, 0);
        check("rst_done", int'(done0), 0, 0);
        check("rst_y", int'(y0), 0, 0);
        check("rst_ready1", int'(ready1), 1, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run0(vecs[i].x, lat, yv);
            ys[i] = yv;
            check($sformatf("y[%0h]", vecs[i].x), int'(yv), int'(vecs[i].y), vecs[i].tol);
            check($sformatf("lat[%0h]", vecs[i].x), lat, vecs[i].lat, 0);
        end

        negp = -ys[0];
        check("odd_half", int'(ys[1]), int'(negp), 0);
        negp = -ys[4];
        check("odd_one", int'(ys[5]), int'(negp), 0);

        // reset in the middle of ITER discards the computation
        run0(16'h0800, lat, yv);
        @(negedge clk);
        x0 = 16'h0800;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_y", int'(y0), 0, 0);
        check("arst_ready", int'(ready0), 1, 0);
        check("arst_done", int'(done0), 0, 0);
        @(negedge clk);
        rst = 1'b1;
        run0(16'h0800, lat, yv);
        check("post_rst_y", int'(yv), 16'h0765, 3);
        check("post_rst_lat", lat, 7, 0);

        // start while busy must not disturb the captured operand
        @(negedge clk);
        x0 = 16'h0800;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        x0 = 16'h1000;
        start0 = 1'b1;
        repeat (2) @(negedge clk);
        start0 = 1'b0;
        dones = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            if (done0) begin
                dones++;
                yv = y0;
            end
        end
        check("busy_dones", dones, 1, 0);
        check("busy_y", int'(yv), 16'h0765, 3);

        // single-term instance
        @(negedge clk);
        x1 = 16'h0400;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done1 && lat < 40);
        check("t1_y", int'(y1), 16'h0400, 0);
        check("t1_lat", lat, 2, 0);
        @(posedge clk);
        #1;
        check("t1_ready", int'(ready1), 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tanh_series_unit.md
# tanh_series_unit

Parametrised fixed-point tanh(x) engine with a start/ready/done handshake and a configurable number of Taylor-series terms. It evaluates tanh on |x| from a coefficient ROM, then restores the sign. It is the successor to the fixed 16-bit tanh datapath/controller pair and sits beside it as the activation-function unit, generalised in width, fraction bits and term count. Adds sign symmetry, result saturation and an optional large-|x| clamp fast path.

## Interface
- WIDTH, 16, data width of X/Y: signed two's complement, Q(WIDTH-FRAC).FRAC.
- FRAC, 12, fraction bits. WIDTH-FRAC ≥ 2 so ±1.0 is representable.
- TERMS, 6, series terms evaluated, range 1..8.
- CLAMP_X, 16'h2000 (2.0), |x| threshold for the clamp fast path. Used only with TANH_CLAMP_EN.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; X sampled only when ready=1.
- X  in  WIDTH  operand.
- ready  out  1  high in IDLE only; reset value 1.
- done  out  1  one-cycle pulse when Y is updated; reset value 0.
- Y  out  WIDTH  result, held until the next done; reset value 0.

## Operation
- FSM: IDLE → SQR → ITER → DONE → IDLE.
- IDLE:
  - start=1 captures a=|X| and neg=X[WIDTH-1]; clears acc; sets term=a, i=0.
  - |X| of the most-negative code saturates to the maximum positive value.
- SQR: sqr = (a*a) >>> FRAC.
- ITER: one term per cycle.
  - acc = acc ± ((coef[i]*term) >>> FRAC); subtract when i is odd, add when i is even.
  - term = (term*sqr) >>> FRAC.
  - i increments; leave ITER after i = TERMS-1.
- DONE: done=1 for exactly one cycle, then IDLE.
- Coefficients are magnitudes in Q2.30: 1, 1/3, 2/15, 17/315, 62/2835, 1382/155925, 21844/6081075, 929569/638512875. Each is arithmetic-shifted right by (30-FRAC) to FRAC format.
- Arithmetic:
  - All products are full width (2·WIDTH) and truncated by arithmetic shift right.
  - acc has WIDTH+4 bits.
  - term and sqr saturate at the maximum positive WIDTH value; they never wrap.
- Result: r = clamp(acc, 0, 1.0), then Y = neg ? -r : r. Y is exactly odd-symmetric.
- start while ready=0 is ignored; the captured X is unaffected.
- start in the DONE cycle is ignored (ready=0).
- rst low at any time forces IDLE immediately: Y=0, ready=1, done=0, internal registers cleared. An in-flight computation is discarded.

## Timing
- Edge e0 samples start in IDLE.
- Normal path:
  - SQR at e1; ITER at e2..e(TERMS+1).
  - Y registers at e(TERMS+1); done is high in the following cycle.
  - Total latency is TERMS+2 edges from e0 to the edge ending the done pulse.
  - ready falls after e0 and rises after the done cycle.
- Throughput: one operation per TERMS+3 cycles.
- Clamp path (macro defined, a ≥ CLAMP_X): IDLE → DONE directly. Y=±1.0 at e1; done is high in the following cycle.

## Configuration
- TANH_CLAMP_EN:
  - Defined: inputs with |X| ≥ CLAMP_X bypass SQR/ITER and return ±1.0 (0x1000 / 0xF000 at defaults) with the clamp-path latency.
  - Undefined: all inputs iterate; results for |x| > π/2 are the saturated series value only.
  - CLAMP_X has no effect when the macro is undefined.

## Structure
- Package tanh_pkg:
  - state enum {IDLE, SQR, ITER, DONE};
  - MAX_TERMS=8;
  - COEF_W=32 and the Q2.30 coefficient magnitude array.
- Sub-module tanh_coef_rom:
  - combinational index → coefficient, with the FRAC alignment shift applied;
  - index width 3.
- The FSM and datapath stay in tanh_series_unit.

## Test plan
- rst low during ITER (X=0x0800) → on the same cycle Y=0, ready=1, done=0; next start runs normally.
- X=0x0800 (0.5), defaults → done 8 edges after start; Y within ±3 LSB of 0x0765 (0.4621).
- X=0xF800 (-0.5) → Y equals the exact two's-complement negation of the previous result.
- start at e0 with X=0x0800, then start again mid-ITER with X=0x1000 → single done; Y matches 0.5 only.
- TANH_CLAMP_EN defined, X=0x3000 then X=0x8000 → done one cycle after e1, Y=0x1000 then 0xF000; without the macro, X=0x3000 takes the full latency.
- X=0x0000 → Y=0x0000; TERMS=1 with X=0x0400 → Y=0x0400, latency 3.
